sr_mdu: RTL and testbench

SR_MDU -- requirements
Module: sr_mdu

---
 rtl/sr_mdu_pkg.sv | 38 +++
 rtl/sr_mdu_step.sv | 32 +++
 rtl/sr_mdu.sv | 117 +++++++++++
 tb/tb_sr_mdu.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sr_mdu_pkg.sv
// Shared CPU definitions: ALU and MDU operation codes plus RV32M decode fields.
// Also holds the MDU state encoding used by the sequential multiply/divide unit.
package sr_mdu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] MDU_MUL   = 2'd0;
    localparam logic [1:0] MDU_MULHU = 2'd1;
    localparam logic [1:0] MDU_DIVU  = 2'd2;
    localparam logic [1:0] MDU_REMU  = 2'd3;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    // Divide and remainder share the restoring datapath.
    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/sr_mdu_step.sv
// One combinational iteration of the sequential MDU.
// Multiply: shift-add on {hi,lo}; divide: restoring trial-subtract on {rem,quo}.
module sr_mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH:0]   diff;
    logic             fits;

    always_comb begin
        sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + (acc_i[0] ? {1'b0, b_i} : '0);
        sh   = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff = sh - {1'b0, b_i};
        fits = (sh >= {1'b0, b_i});
        if (is_div) begin
            // Remainder stays below the divisor, so WIDTH bits always suffice.
            acc_o = {(fits ? diff[WIDTH-1:0] : sh[WIDTH-1:0]),
                     acc_i[WIDTH-2:0], fits};
        end else begin
            acc_o = {sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sr_mdu.sv
// Sequential unsigned multiply/divide unit: fixed WIDTH-cycle iteration,
// one-cycle done pulse, result held until the next accepted start.
module sr_mdu
    import sr_mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] step_acc;

    sr_mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div (mdu_is_div(op_q)),
        .acc_i  (acc_q),
        .b_i    (b_q),
        .acc_o  (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = done_q;
        unique case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = oper;
                    b_d     = srcB;
                    acc_d   = {{WIDTH{1'b0}}, srcA};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    // Odd opcodes (MULHU, REMU) take the upper half.
                    unique case (op_q)
                        MDU_MUL,
                        MDU_DIVU:  result_d = step_acc[WIDTH-1:0];
                        MDU_MULHU,
                        MDU_REMU:  result_d = step_acc[2*WIDTH-1:WIDTH];
                        default:   result_d = step_acc[WIDTH-1:0];
                    endcase
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            op_q     <= MDU_MUL;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_sr_mdu.sv
// Directed self-checking bench for sr_mdu at WIDTH=32 and WIDTH=8.
// Checks latency, busy/done timing, results, ignored starts and reset abort.
module tb_sr_mdu;
    import sr_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start32, start8;
    logic [1:0]  oper32, oper8;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic        busy32, done32, busy8, done8;
    logic [31:0] res32;
    logic [7:0]  res8;

    bit          sel8;
    logic        busy_m, done_m;
    logic [31:0] res_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_mdu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .oper(oper32),
        .srcA(a32), .srcB(b32),
        .busy(busy32), .done(done32), .result(res32)
    );

    sr_mdu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .oper(oper8),
        .srcA(a8), .srcB(b8),
        .busy(busy8), .done(done8), .result(res8)
    );

    assign busy_m = sel8 ? busy8 : busy32;
    assign done_m = sel8 ? done8 : done32;
    assign res_m  = sel8 ? {24'h0, res8} : res32;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_op(input bit w8, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int lat;
        int nbusy;
        int wl;
        wl   = w8 ? 8 : 32;
        sel8 = w8;
        if (w8) begin
            start8 = 1'b1; oper8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = 1'b1; oper32 = op; a32 = a; b32 = b;
        end
        @(posedge clk); #1;
        start8  = 1'b0;
        start32 = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (done_m !== 1'b1 && lat < 200) begin
            if (busy_m === 1'b1) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(wl + 1));
        chk({tag, " busy cycles"}, 64'(nbusy), 64'(wl));
        chk({tag, " busy in done"}, {63'b0, busy_m}, 64'd0);
        chk({tag, " result"}, {32'b0, res_m}, {32'b0, exp});
        @(posedge clk); #1;
        chk({tag, " done pulse"}, {63'b0, done_m}, 64'd0);
        chk({tag, " result held"}, {32'b0, res_m}, {32'b0, exp});
        @(negedge clk);
    endtask

    initial begin
        int ndone;
        int donelat;
        int lastres;
        rst = 1'b1;
        start32 = 1'b0; start8 = 1'b0;
        oper32 = MDU_MUL; oper8 = MDU_MUL;
        a32 = '0; b32 = '0; a8 = '0; b8 = '0;
        sel8 = 1'b0;

        #12;
        chk("reset busy", {63'b0, busy32}, 64'd0);
        chk("reset done", {63'b0, done32}, 64'd0);
        chk("reset result", {32'b0, res32}, 64'd0);
        chk("reset result8", {56'b0, res8}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(1'b0, MDU_MUL,   32'd7, 32'd6, 32'd42, "mul 7*6");
        run_op(1'b0, MDU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'hFFFFFFFE, "mulhu ff");
        run_op(1'b0, MDU_MUL,   32'hFFFFFFFF, 32'hFFFFFFFF,
               32'h00000001, "mul ff");
        run_op(1'b0, MDU_DIVU,  32'd100, 32'd7, 32'd14, "divu 100/7");
        run_op(1'b0, MDU_REMU,  32'd100, 32'd7, 32'd2, "remu 100/7");
        run_op(1'b0, MDU_DIVU,  32'd5, 32'd0, 32'hFFFFFFFF, "divu 5/0");
        run_op(1'b0, MDU_REMU,  32'd5, 32'd0, 32'd5, "remu 5/0");

        // Starts during RUN and DONE must be ignored.
        sel8 = 1'b0;
        start32 = 1'b1; oper32 = MDU_MUL; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk); #1;
        start32 = 1'b0;
        ndone   = 0;
        donelat = -10;
        lastres = 0;
        for (int i = 1; i <= 45; i++) begin
            if (i == donelat + 1)
                chk("no accept in done", {63'b0, busy32}, 64'd0);
            if (done32 === 1'b1) begin
                ndone++;
                donelat = i;
                lastres = int'(res32);
                start32 = 1'b1; oper32 = MDU_DIVU;
                a32 = 32'd9; b32 = 32'd3;
            end else begin
                start32 = (i == 9);
                if (i == 9) begin
                    oper32 = MDU_DIVU; a32 = 32'd9; b32 = 32'd3;
                end
            end
            @(posedge clk); #1;
        end
        start32 = 1'b0;
        chk("ignore done count", 64'(ndone), 64'd1);
        chk("ignore done cycle", 64'(donelat), 64'd33);
        chk("ignore result", 64'(lastres), 64'd12);
        chk("ignore result held", {32'b0, res32}, 64'd12);
        @(negedge clk);

        // Reset in mid-RUN aborts the operation.
        start32 = 1'b1; oper32 = MDU_DIVU; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("pre-rst busy", {63'b0, busy32}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rst busy", {63'b0, busy32}, 64'd0);
        chk("rst done", {63'b0, done32}, 64'd0);
        chk("rst result", {32'b0, res32}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done32 === 1'b1) ndone++;
        end
        chk("no done after rst", 64'(ndone), 64'd0);
        @(negedge clk);
        run_op(1'b0, MDU_MUL, 32'd2, 32'd2, 32'd4, "mul 2*2");

        run_op(1'b1, MDU_MUL,   32'hFF, 32'hFF, 32'h01, "w8 mul ff");
        run_op(1'b1, MDU_MULHU, 32'hFF, 32'hFF, 32'hFE, "w8 mulhu ff");
        run_op(1'b1, MDU_REMU,  32'd200, 32'd7, 32'd4, "w8 remu 200/7");
        run_op(1'b1, MDU_DIVU,  32'd200, 32'd7, 32'd28, "w8 divu 200/7");
        run_op(1'b1, MDU_DIVU,  32'd9, 32'd0, 32'hFF, "w8 divu 9/0");

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
